spi_master: RTL
===============

// Module: spi_master
// PURPOSE
//  Initiator end of the team's SPI link; drives spi_slave (scl/cs/mosi) and captures its miso reply.
//  Mode 0 (scl idles low), LSB first, one DATA_W-bit frame per start request.
//  Sits between a local controller (start/tx_data/rx_data) and the external SPI pins.
// PARAMETERS
//  DATA_W   8  bits per frame; bit 0 sent first
//  CLK_DIV  4  scl half-period in clk cycles; legal range >= 1
// PORTS
//  clk      in   1       system clock. One clock; reset is asynchronous and active-low.
//  rst      in   1       asynchronous, active-low reset
//  start    in   1       request a frame; sampled only while busy==0
//  tx_data  in   DATA_W  frame to send; captured on the accepted start cycle
//  busy     out  1       high from the cycle after an accepted start until done
//  done     out  1       one-cycle pulse at frame end; rx_data valid from that cycle
//  rx_data  out  DATA_W  last received frame; held until the next done
//  scl      out  1       serial clock to slave
//  cs       out  1       chip select, active low
//  mosi     out  1       serial data to slave
//  miso     in   1       serial data from slave
// BEHAVIOUR
//  Reset (rst==0, async): state IDLE; cs=1, scl=0, mosi=0, busy=0, done=0, rx_data=0, counters=0.
//  FSM: IDLE -> SETUP -> (HIGH <-> LOW) x DATA_W -> FINISH -> IDLE.
//  IDLE: start==1 -> latch tx_data into shift reg, bit_cnt=0, go SETUP. start while busy: ignored, no queue.
//  SETUP (CLK_DIV cycles): cs=0, mosi=tx[0], scl=0.
//  HIGH (CLK_DIV cycles): scl=1; slave samples mosi and updates miso on this rising edge.
//  LOW  (CLK_DIV cycles): scl=0; on the cycle entering LOW (falling edge), sample miso into rx_shift[bit_cnt],
//    bit_cnt++, mosi=tx[bit_cnt+1]. After bit DATA_W-1: go FINISH, mosi=0.
//  FINISH (CLK_DIV cycles): cs held low, scl=0; then cs=1, rx_data<=rx_shift, done=1, busy=0, state IDLE.
//  Timing: start accepted at cycle T -> cs falls T+1; first scl rise T+1+CLK_DIV;
//    cs low for CLK_DIV*(2*DATA_W+2) cycles (72 at defaults); done in the cycle cs returns high.
//  start sampled in the done cycle (busy==0) is accepted: cs stays high exactly one cycle between frames.
//  Miso capture offset: slave drives reply bit k after rising edge k; master samples at falling edge k.
//  Slave bit counter is not cleared by cs: master always sends exactly DATA_W bits per frame (no aborts).
//  Reset mid-frame: cs=1, scl=0 immediately (async); no done; rx_data cleared to 0.
//  Outputs scl/cs/mosi are registered; no combinational path from miso or start to any output.
//  Half-period counter width: $clog2(CLK_DIV+1); bit_cnt width: $clog2(DATA_W+1).
// STRUCTURE
//  spi_pkg: typedef enum spi_state_e {IDLE,SETUP,HIGH,LOW,FINISH}; default SPI_DATA_W=8, SPI_CLK_DIV=4.
//  Sub-module spi_clk_div: half-period counter; restart input, tick output every CLK_DIV cycles.
//  Top holds FSM, tx/rx shift registers, bit counter, registered pin outputs.
// TESTING (bench: spi_master wired to spi_slave, both on clk)
//  1 Loopback: tx_data=8'hA5, slave data_in=8'h3C -> done after 73 cycles (defaults), rx_data=8'h3C, slave data_out=8'hA5.
//  2 Pin timing: tx 8'h01 -> cs low 72 cycles, 8 scl rises spaced 8 cycles, mosi=1 only for bit 0 window.
//  3 Busy rejection: start pulsed mid-frame with tx 8'hFF -> ignored; frame completes with original data, one done.
//  4 Back-to-back: start asserted in done cycle, tx 8'h5A then 8'hC3 -> cs high 1 cycle, two dones, slave sees both.
//  5 Reset mid-frame: rst low at bit 3 -> cs=1, scl=0, busy=0, rx_data=0 same cycle; no done; next frame 8'h81 correct.
//  6 CLK_DIV=1, DATA_W=8: tx 8'hF0 / reply 8'h0F -> cs low 18 cycles, rx_data=8'h0F.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI initiator block.
package spi_pkg;

  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    FINISH
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI initiator: tick marks the last cycle of each
// CLK_DIV-cycle phase, restart holds the count at zero.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI initiator, mode 0, LSB first: one DATA_W-bit frame per accepted start,
// with all pin outputs driven straight from flops.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              scl,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = $clog2(DATA_W + 1);

  spi_state_e        state;
  spi_state_e        state_next;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W:0]   rx_cat;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              restart;

  // The phase timer idles at zero so SETUP always gets a full CLK_DIV cycles.
  assign restart = (state == IDLE);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign tx_next = tx_shift >> 1;
  assign rx_cat  = {miso, rx_shift};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (tick)  state_next = HIGH;
      HIGH:    if (tick)  state_next = LOW;
      LOW:     if (tick)  state_next = (bit_cnt == BW'(DATA_W)) ? FINISH : HIGH;
      FINISH:  if (tick)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Falling edge shifts both registers at once; the zeros shifted into tx_shift
  // leave mosi low once the last bit has gone out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      scl      <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= tx_data;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            cs       <= 1'b0;
            mosi     <= tx_data[0];
          end
        end
        SETUP: begin
          if (tick) scl <= 1'b1;
        end
        HIGH: begin
          if (tick) begin
            scl      <= 1'b0;
            rx_shift <= rx_cat[DATA_W:1];
            tx_shift <= tx_next;
            mosi     <= tx_next[0];
            bit_cnt  <= bit_cnt + BW'(1);
          end
        end
        LOW: begin
          if (tick && (bit_cnt != BW'(DATA_W))) scl <= 1'b1;
        end
        FINISH: begin
          if (tick) begin
            cs      <= 1'b1;
            rx_data <= rx_shift;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          cs  <= 1'b1;
          scl <= 1'b0;
        end
      endcase
    end
  end

endmodule
